// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The slave side is the controller: it receives the instruction fields, ALU
// flags and memory handshake, and drives every enable and mux select.
// The master side is the datapath (or a bench standing in for it).
interface multicycle_controller_if;
  // instruction fields, flags and memory handshake (datapath -> controller)
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic       mem_ready;

  // enables and selects (controller -> datapath)
  logic       mem_req;
  logic       mem_w;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_w;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  modport master (
    output op, funct, rd, cond, alu_flags, mem_ready,
    input  mem_req, mem_w, adr_src, ir_write, pc_write, reg_w,
    input  alu_src_a, alu_src_b, result_src, imm_src, reg_src,
    input  alu_control, state
  );

  modport slave (
    input  op, funct, rd, cond, alu_flags, mem_ready,
    output mem_req, mem_w, adr_src, ir_write, pc_write, reg_w,
    output alu_src_a, alu_src_b, result_src, imm_src, reg_src,
    output alu_control, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control unit of the multicycle ARM-subset core. Sequences the shared
// memory port, ALU and register file through fetch/decode/execute, evaluates
// the condition field against an internal NZCV register and drives all
// datapath enables and selects.
//
// Optional build macro: MULTICYCLE_MEM_WAIT_EN
//   defined   -> FETCH, MEMRD and MEMWR wait for mem_ready
//   undefined -> every access completes in one cycle, mem_ready is ignored
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | read instruction at PC, load IR, PC <= PC + 4
// DECODE | read register file, evaluate condition, PC + 8 on ALU
// MEMADR | compute load/store address Rn + imm
// MEMRD  | read data memory at ALU-out
// MEMWB  | write read-data register to Rd
// MEMWR  | write Rd to data memory at ALU-out
// EXECR  | ALU operation with register operand
// EXECI  | ALU operation with immediate operand
// ALUWB  | write ALU-out register to Rd
// BRANCH | PC <= PC + 8 + offset
module multicycle_controller (
  input  logic clk,
  input  logic reset,
  multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b111;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  state_t     state_q, state_d;
  logic       cond_ex_q, cond_ex_d;
  logic [3:0] flags_q, flags_d;
  logic       mem_req_q, mem_req_d;
  logic       mem_w_q, mem_w_d;
  logic       adr_src_q, adr_src_d;

  logic       mem_rdy;
  logic [3:0] cmd;
  logic       cmd_ok;
  logic       cmd_cv;
  logic       cmd_cmp;
  logic [2:0] alu_dec;
  logic       cond_pass;
  logic       n_f, z_f, c_f, v_f;

  logic       ir_write_c;
  logic       pc_write_c;
  logic       reg_w_c;
  logic [1:0] alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [1:0] result_src_c;
  logic [2:0] alu_control_c;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_rdy = bus.mem_ready;
`else
  // every access completes at once; mem_ready has no effect in this build
  assign mem_rdy = 1'b1 | bus.mem_ready;
`endif

  assign cmd     = bus.funct[4:1];
  assign cmd_cmp = (cmd == CMD_CMP);
  assign {n_f, z_f, c_f, v_f} = flags_q;

  // decode the data-processing command into an ALU op; unknown commands run as a NOP add
  always_comb begin
    alu_dec = ALU_ADD;
    cmd_ok  = 1'b1;
    cmd_cv  = 1'b0;
    case (cmd)
      CMD_ADD: begin alu_dec = ALU_ADD; cmd_cv = 1'b1; end
      CMD_SUB: begin alu_dec = ALU_SUB; cmd_cv = 1'b1; end
      CMD_CMP: begin alu_dec = ALU_SUB; cmd_cv = 1'b1; end
      CMD_AND: alu_dec = ALU_AND;
      CMD_ORR: alu_dec = ALU_ORR;
      CMD_EOR: alu_dec = ALU_EOR;
      default: cmd_ok = 1'b0;
    endcase
  end

  // ARM condition field against the current NZCV register
  always_comb begin
    cond_pass = 1'b0;
    case (bus.cond)
      4'h0: cond_pass = z_f;
      4'h1: cond_pass = ~z_f;
      4'h2: cond_pass = c_f;
      4'h3: cond_pass = ~c_f;
      4'h4: cond_pass = n_f;
      4'h5: cond_pass = ~n_f;
      4'h6: cond_pass = v_f;
      4'h7: cond_pass = ~v_f;
      4'h8: cond_pass = c_f & ~z_f;
      4'h9: cond_pass = ~c_f | z_f;
      4'hA: cond_pass = (n_f == v_f);
      4'hB: cond_pass = (n_f != v_f);
      4'hC: cond_pass = ~z_f & (n_f == v_f);
      4'hD: cond_pass = z_f | (n_f != v_f);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // next state, condition latch, flag update and next-state decode of the memory strobes
  always_comb begin
    state_d   = state_q;
    cond_ex_d = cond_ex_q;
    flags_d   = flags_q;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        cond_ex_d = cond_pass;
        case (bus.op)
          2'd0:    state_d = bus.funct[5] ? S_EXECI : S_EXECR;
          2'd1:    state_d = S_MEMADR;
          2'd2:    state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = bus.funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXECR, S_EXECI: begin
        state_d = (cmd_ok && !cmd_cmp) ? S_ALUWB : S_FETCH;
        if (bus.funct[0] && cond_ex_q && cmd_ok) begin
          flags_d[3:2] = bus.alu_flags[3:2];
          if (cmd_cv) flags_d[1:0] = bus.alu_flags[1:0];
        end
      end
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase

    // registered so they hold steady across a whole (possibly stretched) access
    mem_req_d = (state_d inside {S_FETCH, S_MEMRD, S_MEMWR});
    adr_src_d = (state_d inside {S_MEMRD, S_MEMWR});
    mem_w_d   = (state_d == S_MEMWR) && cond_ex_d;
  end

  // state, condition, flags and memory strobes; reset abandons any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cond_ex_q <= 1'b0;
      flags_q   <= 4'b0000;
      mem_req_q <= 1'b1;
      mem_w_q   <= 1'b0;
      adr_src_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cond_ex_q <= cond_ex_d;
      flags_q   <= flags_d;
      mem_req_q <= mem_req_d;
      mem_w_q   <= mem_w_d;
      adr_src_q <= adr_src_d;
    end
  end

  // per-state enables and selects; architectural writes outside FETCH are gated by cond_ex_q
  always_comb begin
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    reg_w_c       = 1'b0;
    alu_src_a_c   = 2'd0;
    alu_src_b_c   = 2'd0;
    result_src_c  = 2'd0;
    alu_control_c = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_a_c  = 2'd1;
        alu_src_b_c  = 2'd2;
        result_src_c = 2'd2;
        ir_write_c   = mem_rdy;
        pc_write_c   = mem_rdy;
      end
      S_DECODE: begin
        alu_src_a_c  = 2'd1;
        alu_src_b_c  = 2'd2;
        result_src_c = 2'd2;
      end
      S_MEMADR: alu_src_b_c = 2'd1;
      S_MEMWB: begin
        result_src_c = 2'd1;
        reg_w_c      = cond_ex_q;
        pc_write_c   = cond_ex_q && (bus.rd == 4'd15);
      end
      S_EXECR: alu_control_c = alu_dec;
      S_EXECI: begin
        alu_src_b_c   = 2'd1;
        alu_control_c = alu_dec;
      end
      S_ALUWB: begin
        reg_w_c    = cond_ex_q;
        pc_write_c = cond_ex_q && (bus.rd == 4'd15);
      end
      S_BRANCH: begin
        alu_src_b_c  = 2'd1;
        result_src_c = 2'd2;
        pc_write_c   = cond_ex_q;
      end
      default: ;
    endcase
  end

  // IR and PC must not load while reset holds the FSM in FETCH
  assign bus.ir_write    = ir_write_c & ~reset;
  assign bus.pc_write    = pc_write_c & ~reset;
  assign bus.reg_w       = reg_w_c;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_w       = mem_w_q;
  assign bus.adr_src     = adr_src_q;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.result_src  = result_src_c;
  assign bus.alu_control = alu_control_c;
  assign bus.imm_src     = bus.op;
  assign bus.reg_src     = {(bus.op == 2'd1) & ~bus.funct[0], (bus.op == 2'd2)};
  assign bus.state       = state_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multicycle ARM-subset core. It sequences the shared datapath (one memory port, one ALU, one register file) through fetch, decode and execute states. It evaluates the ARM condition field against an internal NZCV flag register. It drives every datapath enable and mux select, so it replaces the single-cycle decode path once the core moves to a shared memory.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  2  instr[27:26]: 0 data-processing, 1 memory, 2 branch, 3 undefined
- funct  in  6  instr[25:20]: [5] immediate flag (I), [4:1] cmd, [0] S (DP) / L (memory)
- rd  in  4  instr[15:12]
- cond  in  4  instr[31:28]
- alu_flags  in  4  {N,Z,C,V} from the ALU, valid in the current cycle
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access requested this cycle
- mem_w  out  1  memory write enable
- adr_src  out  1  0 = PC, 1 = ALU-out register
- ir_write  out  1  load the instruction register
- pc_write  out  1  load PC from the result bus
- reg_w  out  1  register-file write enable
- alu_src_a  out  2  0 = Rn, 1 = PC, 2 = ALU-out
- alu_src_b  out  2  0 = Rm, 1 = extended immediate, 2 = constant 4
- result_src  out  2  0 = ALU-out register, 1 = read-data register, 2 = ALU result (direct)
- imm_src  out  2  equal to op
- reg_src  out  2  [0] = (op==2), [1] = (op==1 & ~funct[0])
- alu_control  out  3  000 add, 001 sub, 010 and, 011 orr, 111 eor
- state  out  4  current state, for debug

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10–15 go to FETCH.
- State transitions:
  - FETCH → DECODE.
  - DECODE → MEMADR (op 1), EXECI (op 0, funct[5]=1), EXECR (op 0, funct[5]=0), BRANCH (op 2), FETCH (op 3).
  - MEMADR → MEMRD if L=1, else MEMWR.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECR/EXECI → ALUWB → FETCH. EXECR/EXECI go directly to FETCH for CMP (cmd 1010) and for unsupported cmd.
  - BRANCH → FETCH.
- Per-state outputs (unlisted outputs are 0):
  - FETCH: mem_req, alu_src_a=1, alu_src_b=2, result_src=2, add, ir_write, pc_write.
  - DECODE: alu_src_a=1, alu_src_b=2, result_src=2, add.
  - MEMADR: alu_src_b=1, add.
  - MEMRD: mem_req, adr_src=1.
  - MEMWB: result_src=1, reg_w.
  - MEMWR: mem_req, adr_src=1, mem_w.
  - EXECR: alu_src_b=0, alu_control from cmd.
  - EXECI: alu_src_b=1, alu_control from cmd.
  - ALUWB: reg_w.
  - BRANCH: alu_src_b=1, result_src=2, add, pc_write.
- cmd decode: 0100 ADD→000, 0010 SUB→001, 0000 AND→010, 1100 ORR→011, 0001 EOR→111, 1010 CMP→001 (no register write). Any other cmd executes as a NOP: add, no register write, no flag write.
- Condition evaluation: cond_ex_q is latched at the end of DECODE from the flag register.
  - Codes 0–13 follow the standard ARM meanings (EQ…LE).
  - 1110 (AL) → 1; 1111 → 0.
- Gating by cond_ex_q: reg_w, mem_w and pc_write are ANDed with cond_ex_q outside FETCH. A failed store still passes through MEMWR with mem_req=1 and mem_w=0.
- Register write to PC: in MEMWB/ALUWB, if rd==15, pc_write = reg_w.
- Flag update: at the end of EXECR/EXECI when funct[0]=1, cond_ex_q=1 and cmd is supported.
  - N and Z always load from alu_flags.
  - C and V load only for ADD, SUB and CMP.

## Timing
- Zero-wait latencies (cycles): LDR 5, STR 4, data-processing 4, CMP 3, B 3, undefined op 2.
- Asynchronous reset forces: state=FETCH, flags=0000, cond_ex_q=0, ir_write=0, pc_write=0. Reset in any state, including during an access, abandons the instruction.
- mem_req, mem_w and adr_src are Moore outputs and stay stable for the whole access.

## Configuration
- MULTICYCLE_MEM_WAIT_EN defined:
  - FETCH, MEMRD and MEMWR hold until mem_ready=1.
  - ir_write and pc_write in FETCH assert only in the mem_ready cycle.
  - MEMRD/MEMWR advance only on mem_ready.
  - Each wait cycle adds one cycle of latency.
- MULTICYCLE_MEM_WAIT_EN undefined: mem_ready is ignored and treated as 1.

## Test plan
- ADD r1 (cond AL, I=0, S=0) → states 0,1,6,8,0; reg_w=1 only in state 8; alu_control=000 in state 6.
- CMP with alu_flags=0100 at EXECR, then ADDEQ → flags=0100; CMP passes 0,1,6,0; ADDEQ gets reg_w=1 in ALUWB.
- ADDSNE with Z=1 at DECODE → reg_w=0 and no flag change, even though its own ALU result would clear Z.
- LDR with rd=15 → MEMWB asserts reg_w=1 and pc_write=1; STR asserts mem_w=1 only in state 5.
- With MULTICYCLE_MEM_WAIT_EN, mem_ready low for 3 cycles in FETCH → state stays 0 for 4 cycles; ir_write pulses once, on the 4th cycle.
- Reset asserted in MEMRD → state=0 and flags=0 immediately; first post-reset cycle fetches normally.
